// File: rtl/multi_edge_detect.sv
// Multi-channel input conditioner: each channel has a synchronizer, a debouncer and an edge qualifier.
// Each channel drives a one-cycle change pulse, a debounced level and a sticky event flag.
module multi_edge_detect #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] evt_clr,
  output logic [CHANNELS-1:0] sig_chng,
  output logic [CHANNELS-1:0] sig_lvl,
  output logic [CHANNELS-1:0] evt
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Decide whether an accepted level change is reported under the given mode.
  function automatic logic edge_qualifies(input logic [1:0] edge_mode, input logic new_lvl);
    logic q;
    case (edge_mode)
      2'b00:   q = new_lvl;
      2'b01:   q = ~new_lvl;
      2'b10:   q = 1'b1;
      2'b11:   q = 1'b0;
      default: q = 1'b0;
    endcase
    return q;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   lvl_r;
    logic                   chng_r;
    logic                   evt_r;

    logic                   sync_out_s;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   lvl_nxt_s;
    logic                   accept_s;
    logic                   qualify_s;
    logic                   evt_nxt_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Debounce: count consecutive disagreeing samples; the last one in the run flips the level.
    always_comb begin
      cnt_nxt_s = {CNT_W{1'b0}};
      lvl_nxt_s = lvl_r;
      accept_s  = 1'b0;
      if (sync_out_s != lvl_r) begin
        if (cnt_r == CNT_LAST) begin
          accept_s  = 1'b1;
          lvl_nxt_s = sync_out_s;
          cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end else begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
    end

    // Edge qualification and sticky flag; a set on the clearing edge wins so no event is lost.
    always_comb begin
      qualify_s = 1'b0;
      evt_nxt_s = evt_r;
      if (accept_s) begin
        qualify_s = edge_qualifies(mode, sync_out_s);
      end else begin
        qualify_s = 1'b0;
      end
      if (qualify_s) begin
        evt_nxt_s = 1'b1;
      end else if (evt_clr[i]) begin
        evt_nxt_s = 1'b0;
      end else begin
        evt_nxt_s = evt_r;
      end
    end

    // Channel state registers; reset discards any partial debounce run.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_r <= {SYNC_STAGES{1'b0}};
        cnt_r  <= {CNT_W{1'b0}};
        lvl_r  <= 1'b0;
        chng_r <= 1'b0;
        evt_r  <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], sig[i]};
        cnt_r  <= cnt_nxt_s;
        lvl_r  <= lvl_nxt_s;
        chng_r <= qualify_s;
        evt_r  <= evt_nxt_s;
      end
    end

    assign sig_chng[i] = chng_r;
    assign sig_lvl[i]  = lvl_r;
    assign evt[i]      = evt_r;
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect: default config (A) and a 1-channel, 3-stage, no-debounce config (B).
module tb_multi_edge_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] sig_a, clr_a;
  logic [1:0] mode_a, mode_b;
  logic [0:0] sig_b, clr_b;
  logic [3:0] chng_a, lvl_a, evt_a;
  logic [0:0] chng_b, lvl_b, evt_b;

  multi_edge_detect #(.CHANNELS(4), .SYNC_STAGES(2), .DB_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_a), .sig(sig_a), .mode(mode_a), .evt_clr(clr_a),
    .sig_chng(chng_a), .sig_lvl(lvl_a), .evt(evt_a));

  multi_edge_detect #(.CHANNELS(1), .SYNC_STAGES(3), .DB_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .sig(sig_b), .mode(mode_b), .evt_clr(clr_b),
    .sig_chng(chng_b), .sig_lvl(lvl_b), .evt(evt_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: keep the raw-input history per edge; a level flips once the last DB samples
  // seen at the synchronizer output all disagree with the current level.
  int         ss [2] = '{2, 3};
  int         db [2] = '{4, 1};
  int         nc [2] = '{4, 1};
  logic       hist [2][4][8];
  logic [3:0] m_lvl [2];
  logic [3:0] m_chng [2];
  logic [3:0] m_evt [2];

  task automatic model_step(input int n, input logic r, input logic [3:0] s,
                            input logic [1:0] m, input logic [3:0] clr);
    for (int c = 0; c < nc[n]; c++) begin
      logic acc, nl, q;
      if (r) begin
        m_lvl[n][c]  = 1'b0;
        m_chng[n][c] = 1'b0;
        m_evt[n][c]  = 1'b0;
        for (int k = 0; k < 8; k++) hist[n][c][k] = 1'b0;
      end else begin
        acc = 1'b1;
        for (int j = 0; j < db[n]; j++)
          if (hist[n][c][ss[n]-1+j] == m_lvl[n][c]) acc = 1'b0;
        nl = ~m_lvl[n][c];
        q  = acc && ((m == 2'b00 && nl) || (m == 2'b01 && !nl) || (m == 2'b10));
        m_chng[n][c] = q;
        if (acc) m_lvl[n][c] = nl;
        if (q) m_evt[n][c] = 1'b1;
        else if (clr[c]) m_evt[n][c] = 1'b0;
        for (int k = 7; k > 0; k--) hist[n][c][k] = hist[n][c][k-1];
        hist[n][c][0] = s[c];
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare all outputs after the edge.
  task automatic tick();
    model_step(0, rst_a, sig_a, mode_a, clr_a);
    model_step(1, rst_b, {3'b000, sig_b}, mode_b, {3'b000, clr_b});
    @(posedge clk);
    #1;
    chk("a_chng", chng_a, m_chng[0]);
    chk("a_lvl",  lvl_a,  m_lvl[0]);
    chk("a_evt",  evt_a,  m_evt[0]);
    chk("b_chng", {3'b000, chng_b}, m_chng[1]);
    chk("b_lvl",  {3'b000, lvl_b},  m_lvl[1]);
    chk("b_evt",  {3'b000, evt_b},  m_evt[1]);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_lvl[n] = 4'h0; m_chng[n] = 4'h0; m_evt[n] = 4'h0;
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 8; k++) hist[n][c][k] = 1'b0;
    end
    rst_a = 1'b1; sig_a = 4'hF; mode_a = 2'b00; clr_a = 4'h0;
    rst_b = 1'b1; sig_b = 1'b0; mode_b = 2'b10; clr_b = 1'b0;

    // Reset with inputs high, then power-up rising pulse on every channel at E5.
    repeat (3) tick();
    chk("rst_chng", chng_a, 4'h0);
    chk("rst_lvl",  lvl_a,  4'h0);
    chk("rst_evt",  evt_a,  4'h0);
    rst_a = 1'b0;
    repeat (5) tick();
    chk("pu_e4_chng", chng_a, 4'h0);
    tick();
    chk("pu_e5_chng", chng_a, 4'hF);
    chk("pu_e5_lvl",  lvl_a,  4'hF);
    tick();
    chk("pu_e6_chng", chng_a, 4'h0);
    chk("pu_evt",     evt_a,  4'hF);
    clr_a = 4'hF; tick(); clr_a = 4'h0;
    chk("clr_all", evt_a, 4'h0);
    sig_a = 4'h0; repeat (10) tick();
    chk("fall_m00_lvl", lvl_a, 4'h0);
    chk("fall_m00_evt", evt_a, 4'h0);

    // Clean rise and fall on ch0 in mode 10.
    mode_a = 2'b10; sig_a = 4'h1;
    repeat (5) tick();
    chk("m10_rise_e4", chng_a, 4'h0);
    tick();
    chk("m10_rise_e5", chng_a, 4'h1);
    repeat (14) tick();
    sig_a = 4'h0;
    repeat (6) tick();
    chk("m10_fall_e5", chng_a, 4'h1);
    repeat (10) tick();

    // Glitch of 3 samples is rejected; 4 samples is accepted.
    clr_a = 4'hF; tick(); clr_a = 4'h0;
    sig_a = 4'h2; repeat (3) tick(); sig_a = 4'h0; repeat (10) tick();
    chk("glitch_lvl", lvl_a, 4'h0);
    chk("glitch_evt", evt_a, 4'h0);
    sig_a = 4'h2; repeat (4) tick(); sig_a = 4'h0; repeat (2) tick();
    chk("min_pulse_chng", chng_a, 4'h2);
    repeat (10) tick();
    chk("min_pulse_evt", evt_a, 4'h2);

    // Mode filtering: 00, 01, 11 over a rise/fall pair on ch0.
    for (int mi = 0; mi < 3; mi++) begin
      mode_a = (mi == 0) ? 2'b00 : (mi == 1) ? 2'b01 : 2'b11;
      clr_a = 4'hF; tick(); clr_a = 4'h0;
      sig_a = 4'h1; repeat (10) tick();
      chk("mode_rise_lvl", lvl_a, 4'h1);
      sig_a = 4'h0; repeat (10) tick();
      if (mi == 2) chk("m11_evt", evt_a, 4'h0);
      else chk("mode_evt", evt_a, 4'h1);
    end

    // Sticky event on ch2, and set winning over a simultaneous clear.
    mode_a = 2'b00; clr_a = 4'hF; tick(); clr_a = 4'h0;
    sig_a = 4'h4; repeat (10) tick();
    chk("sticky_set", evt_a, 4'h4);
    repeat (5) tick();
    chk("sticky_hold", evt_a, 4'h4);
    clr_a = 4'h4; tick(); clr_a = 4'h0;
    chk("sticky_clr", evt_a, 4'h0);
    sig_a = 4'h0; repeat (10) tick();
    sig_a = 4'h4; repeat (5) tick();
    clr_a = 4'h4; tick(); clr_a = 4'h0;
    chk("set_wins_evt",  evt_a,  4'h4);
    chk("set_wins_chng", chng_a, 4'h4);
    repeat (4) tick();

    // Reset at E3 of a rise on ch3 discards the partial run.
    sig_a = 4'h8; repeat (3) tick();
    rst_a = 1'b1; sig_a = 4'h0; tick(); rst_a = 1'b0;
    repeat (10) tick();
    chk("mid_rst_lvl", lvl_a, 4'h0);
    chk("mid_rst_evt", evt_a, 4'h0);

    // Small config: three sync stages, single-sample debounce, pulse at E3.
    rst_b = 1'b0; repeat (4) tick();
    sig_b = 1'b1; repeat (3) tick();
    chk("b_e2_chng", {3'b000, chng_b}, 4'h0);
    tick();
    chk("b_e3_chng", {3'b000, chng_b}, 4'h1);
    chk("b_e3_lvl",  {3'b000, lvl_b},  4'h1);
    sig_b = 1'b0; repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
